gpio_in_capture: RTL and testbench
==================================

GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive stable cycles required to accept a pin change (used only with GPIO_DEBOUNCE_EN; legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port wr_en, input, 1, register write strobe, qualified by addr.
REQ-005 SHALL have port addr, input, 32, bus address; only addr[7:0] is decoded.
REQ-006 SHALL have port wr_data, input, 32, write data.
REQ-007 SHALL have port rd_data, output, 32, combinational read data for addr.
REQ-008 SHALL have port gpio_in, input, 8, asynchronous external input pins.
REQ-009 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-010 SHALL implement this register map on addr[7:0]: 0x00 DATA (RO, filtered pin value), 0x04 RISE_EN (RW), 0x08 FALL_EN (RW), 0x0C STATUS (W1C), 0x10 IRQ_EN (RW); all registers are 8 bits in bits [7:0].
REQ-011 SHALL return zero in rd_data[31:8] and return zero for unmapped addresses; writes to DATA or unmapped addresses are ignored.
REQ-012 SHALL pass each gpio_in bit through a two-flop synchronizer (sync1, sync2).
REQ-013 SHALL derive the filtered value filt from sync2 (see REQ-022/023) and hold the previous value prev, updated every cycle.
REQ-014 SHALL set STATUS[i] on the clock edge where RISE_EN[i] & filt[i] & ~prev[i], or FALL_EN[i] & ~filt[i] & prev[i].
REQ-015 SHALL clear STATUS[i] when wr_en is high, addr[7:0]==0x0C and wr_data[i]==1; writing 0 leaves the bit unchanged.
REQ-016 SHALL give set priority over clear when an edge event and a W1C on the same bit occur in the same cycle.
REQ-017 SHALL drive irq = |(STATUS & IRQ_EN) combinationally from registers, with no additional latency.
REQ-018 SHALL give a pin transition a latency of 3 rising edges to STATUS without debounce (sync1, sync2, STATUS set), and 3+DEBOUNCE_CYCLES with debounce.
REQ-019 SHALL update RW registers one cycle after the write strobe, and reflect the updated value on rd_data in the following cycle.
REQ-020 SHALL NOT apply a changed RISE_EN or FALL_EN retroactively; only edges occurring after the update set STATUS.

Reset
REQ-021 SHALL asynchronously clear sync1, sync2, filt, prev, RISE_EN, FALL_EN, STATUS, IRQ_EN and all debounce counters to 0 while rst_n is low; irq=0 and rd_data at 0x00 reads 0 during reset; a pin held high through reset deassertion produces a rising event if RISE_EN is later set before filt rises; reset mid-debounce discards the count.

Configuration
REQ-022 With GPIO_DEBOUNCE_EN defined, SHALL update filt[i] to sync2[i] only after sync2[i] differs from filt[i] for DEBOUNCE_CYCLES consecutive cycles; any cycle where they are equal resets that pin's counter to 0.
REQ-023 Without GPIO_DEBOUNCE_EN, SHALL set filt = sync2 directly, instantiate no counters and ignore DEBOUNCE_CYCLES.

Structure
REQ-024 SHALL take the register offset constants (GPIO_IN_DATA, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_STATUS, GPIO_IRQ_EN) and the pin width 8 from the shared package gpio_pkg.
REQ-025 SHALL implement debounce in sub-module gpio_debounce (one bit, counter plus filtered output), instantiated 8 times under GPIO_DEBOUNCE_EN.

Verification
REQ-026 Reset: set gpio_in=8'hA5 and pulse rst_n low mid-simulation -> all reads return 0 and irq=0 during reset; DATA=0xA5 three edges after release (no debounce).
REQ-027 Rising edge: RISE_EN=0x01, IRQ_EN=0x01, gpio_in[0] 0->1 -> STATUS=0x01 and irq=1 on the 3rd edge; a falling edge does not set the bit.
REQ-028 W1C: STATUS=0x03, write 0x01 to 0x0C -> STATUS=0x02 next cycle; write 0x00 -> unchanged.
REQ-029 Collision: a W1C of bit 2 in the same cycle that a falling event on bit 2 (FALL_EN=0x04) sets it -> STATUS[2] remains 1.
REQ-030 Debounce (DEBOUNCE_CYCLES=4): a 3-cycle glitch on gpio_in[7] -> no DATA change and no STATUS; a stable high -> DATA[7]=1 and STATUS[7] set exactly 7 edges after the change.
REQ-031 Unmapped: read 0x14 -> 0; write 0xFF to 0x00 -> DATA unaffected.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared pin width and register offsets for the GPIO input capture block.
package gpio_pkg;
    localparam int         GPIO_W       = 8;
    localparam logic [7:0] GPIO_IN_DATA = 8'h00;
    localparam logic [7:0] GPIO_RISE_EN = 8'h04;
    localparam logic [7:0] GPIO_FALL_EN = 8'h08;
    localparam logic [7:0] GPIO_STATUS  = 8'h0C;
    localparam logic [7:0] GPIO_IRQ_EN  = 8'h10;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one-bit filter; the output follows the input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [7:0] r_cnt;
    logic       r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (i_d == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_q   <= i_d;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
    assign o_q = r_q;
endmodule

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: synchronised GPIO inputs with edge-detect status (W1C) and level irq.
// Define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter after the synchronizer.
module gpio_in_capture
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              irq
);
    logic [GPIO_W-1:0] r_sync1, r_sync2, r_prev;
    logic [GPIO_W-1:0] r_rise_en, r_fall_en, r_status, r_irq_en;
    logic [GPIO_W-1:0] w_filt, w_set, w_clr;
    logic [7:0]        w_addr;
    logic              w_unused;

    assign w_addr   = addr[7:0];
    assign w_unused = &{1'b0, addr[31:8], wr_data[31:GPIO_W], DEBOUNCE_CYCLES != 0};

`ifdef GPIO_DEBOUNCE_EN
    for (genvar i = 0; i < GPIO_W; i++) begin : g_db
        gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .i_d  (r_sync2[i]),
            .o_q  (w_filt[i])
        );
    end
`else
    assign w_filt = r_sync2;
`endif

    // Set wins over a same-cycle W1C because it is OR-ed in after the clear mask.
    assign w_set = (r_rise_en & w_filt & ~r_prev) | (r_fall_en & ~w_filt & r_prev);
    assign w_clr = (wr_en && w_addr == GPIO_STATUS) ? wr_data[GPIO_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_irq_en  <= '0;
        end else begin
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;
            r_prev   <= w_filt;
            r_status <= (r_status & ~w_clr) | w_set;
            if (wr_en && w_addr == GPIO_RISE_EN) r_rise_en <= wr_data[GPIO_W-1:0];
            if (wr_en && w_addr == GPIO_FALL_EN) r_fall_en <= wr_data[GPIO_W-1:0];
            if (wr_en && w_addr == GPIO_IRQ_EN)  r_irq_en  <= wr_data[GPIO_W-1:0];
        end
    end

    always_comb begin
        rd_data = {24'b0,
                   w_addr == GPIO_IN_DATA ? w_filt    :
                   w_addr == GPIO_RISE_EN ? r_rise_en :
                   w_addr == GPIO_FALL_EN ? r_fall_en :
                   w_addr == GPIO_STATUS  ? r_status  :
                   w_addr == GPIO_IRQ_EN  ? r_irq_en  : 8'h00};
    end

    assign irq = |(r_status & r_irq_en);
endmodule

// File: tb/tb_gpio_in_capture.sv
// tb_gpio_in_capture: directed and randomised checks against a pin-history reference model.
module tb_gpio_in_capture;
    logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, irq;
    logic [31:0] addr = '0, wr_data = '0, rd_data;
    logic [7:0]  gpio_in = '0;
    int          checks = 0, errors = 0;

`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    gpio_in_capture #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .gpio_in(gpio_in), .irq(irq)
    );

    always #5 clk = ~clk;

    // hist[0] is the pin value sampled at the latest edge, hist[1] the one before, ...
    logic [7:0] hist [3];
    logic [7:0] m_rise, m_fall, m_stat, m_ien;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[7:0])
            8'h00:   return {24'b0, hist[1]};
            8'h04:   return {24'b0, m_rise};
            8'h08:   return {24'b0, m_fall};
            8'h0C:   return {24'b0, m_stat};
            8'h10:   return {24'b0, m_ien};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_rise = '0; m_fall = '0; m_stat = '0; m_ien = '0;
    endtask

    task automatic tick(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] set, clr;
        wr_en = we; addr = a; wr_data = d;
        @(posedge clk);
        set = (m_rise & hist[1] & ~hist[2]) | (m_fall & ~hist[1] & hist[2]);
        clr = (we && a[7:0] == 8'h0C) ? d[7:0] : 8'h00;
        m_stat = (m_stat & ~clr) | set;
        if (we && a[7:0] == 8'h04) m_rise = d[7:0];
        if (we && a[7:0] == 8'h08) m_fall = d[7:0];
        if (we && a[7:0] == 8'h10) m_ien  = d[7:0];
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = gpio_in;
        #1;
        wr_en = 1'b0;
`ifndef GPIO_DEBOUNCE_EN
        check("model_rd", rd_data, m_read(a));
        check("model_irq", 32'(irq), 32'(|(m_stat & m_ien)));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 32'h0);
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        logic [31:0] amap [6];
        logic [31:0] r;
        amap = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rdchk("rst_data", 32'h00, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        tick(1'b1, 32'h04, 32'h01);
        tick(1'b1, 32'h10, 32'h01);
        rdchk("rise_en_rb", 32'h04, 32'h01);
        rdchk("irq_en_rb", 32'h10, 32'h01);

        gpio_in = 8'h01;
        idle(LAT - 1);
        rdchk("rise_early", 32'h0C, 32'h00);
        check("irq_early", 32'(irq), 32'h0);
        idle(1);
        rdchk("rise_set", 32'h0C, 32'h01);
        check("irq_set", 32'(irq), 32'h1);
        gpio_in = 8'h00;
        idle(LAT + 1);
        rdchk("fall_ignored", 32'h0C, 32'h01);

        tick(1'b1, 32'h04, 32'h03);
        gpio_in = 8'h03;
        idle(LAT);
        rdchk("w1c_pre", 32'h0C, 32'h03);
        tick(1'b1, 32'h0C, 32'h01);
        rdchk("w1c_one", 32'h0C, 32'h02);
        tick(1'b1, 32'h0C, 32'h00);
        rdchk("w1c_zero", 32'h0C, 32'h02);
        tick(1'b1, 32'h0C, 32'hFF);
        rdchk("w1c_all", 32'h0C, 32'h00);
        check("irq_clr", 32'(irq), 32'h0);

        tick(1'b1, 32'h08, 32'h04);
        gpio_in = 8'h07;
        idle(LAT + 1);
        rdchk("coll_pre", 32'h0C, 32'h00);
        gpio_in = 8'h03;
        idle(LAT - 1);
        tick(1'b1, 32'h0C, 32'h04);
        rdchk("collision", 32'h0C, 32'h04);

        rdchk("unmapped_rd", 32'h14, 32'h0);
        tick(1'b1, 32'h00, 32'hFF);
        rdchk("data_ro", 32'h00, 32'h03);

`ifndef GPIO_DEBOUNCE_EN
        for (int n = 0; n < 600; n++) begin
            gpio_in = gpio_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            r = $urandom;
            tick($urandom_range(0, 9) < 4, {r[31:8], amap[$urandom_range(0, 5)][7:0]}, $urandom);
        end
`endif

        tick(1'b1, 32'h04, 32'hFF);
        tick(1'b1, 32'h10, 32'hFF);
        gpio_in = 8'hA5;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) rdchk("rst_mid_rd", amap[i], 32'h0);
        check("rst_mid_irq", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        rdchk("rst_hold_data", 32'h00, 32'h0);
        rst_n = 1'b1;
        m_reset();
        idle(LAT);
        rdchk("rst_release_data", 32'h00, 32'hA5);

`ifdef GPIO_DEBOUNCE_EN
        tick(1'b1, 32'h04, 32'h80);
        tick(1'b1, 32'h10, 32'h80);
        gpio_in = 8'h25;
        idle(12);
        tick(1'b1, 32'h0C, 32'hFF);
        gpio_in = 8'hA5;
        idle(3);
        gpio_in = 8'h25;
        idle(12);
        rdchk("glitch_data", 32'h00, 32'h25);
        rdchk("glitch_status", 32'h0C, 32'h00);
        gpio_in = 8'hA5;
        idle(6);
        rdchk("db_early", 32'h0C, 32'h00);
        idle(1);
        rdchk("db_data", 32'h00, 32'hA5);
        rdchk("db_status", 32'h0C, 32'h80);
        check("db_irq", 32'(irq), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
